lsu_mmio: RTL and testbench

LSU_MMIO -- requirements
Module: lsu_mmio

---
 rtl/lsu_mmio.sv | 164 ++++++++++++++++
 tb/tb_lsu_mmio.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_mmio.sv
// Load/store unit with a word-addressed data memory and memory-mapped I/O.
// One fixed-latency access per request; results are registered for one cycle.
module lsu_mmio #(
  parameter int ADDR_W  = 12,
  parameter int DMEM_AW = 9,
  parameter int N_HEX   = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              uns_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       st_i,
  input  logic [31:0]       sw_i,
  output logic              busy_o,
  output logic              ack_o,
  output logic              err_o,
  output logic [31:0]       ld_o,
  output logic [31:0]       io_hex_o [0:N_HEX-1],
  output logic [31:0]       io_ledr_o,
  output logic [31:0]       io_ledg_o,
  output logic [31:0]       io_lcd_o
);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e state_q, state_d;
  logic              we_q, uns_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       st_q;
  logic [31:0]       sw_s1_q, sw_s2_q;
  logic              ack_q, err_q;
  logic [31:0]       ld_q;
  logic [31:0]       dmem_q [2**DMEM_AW];

  logic [ADDR_W-1:0]  wa;
  logic [DMEM_AW-1:0] widx;
  logic [N_HEX-1:0]   hex_sel;
  logic is_dmem, is_ledr, is_ledg, is_lcd, is_sw, mapped;
  logic err_d, acc, wr_en;
  logic [3:0]  lanes;
  logic [31:0] bmask, wdata, rword, lshift, ld_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_i) state_d = ACCESS;
      ACCESS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q == ACCESS);
  assign acc    = (state_q == ACCESS);
  assign ack_o  = ack_q;
  assign err_o  = err_q;
  assign ld_o   = ld_q;

  always_comb begin
    wa      = {addr_q[ADDR_W-1:2], 2'b00};
    widx    = addr_q[DMEM_AW+1:2];
    is_dmem = addr_q < ADDR_W'(12'h800);
    is_ledr = wa == ADDR_W'(12'h880);
    is_ledg = wa == ADDR_W'(12'h890);
    is_lcd  = wa == ADDR_W'(12'h8A0);
    is_sw   = wa == ADDR_W'(12'h900);
    hex_sel = '0;
    for (int k = 0; k < N_HEX; k++)
      hex_sel[k] = wa == ADDR_W'(32'h800 + 32'(4 * k));
    mapped = is_dmem | is_ledr | is_ledg | is_lcd | is_sw | (|hex_sel);
    err_d = (size_q == 2'b11)
          | (size_q == 2'b01 && addr_q[0])
          | (size_q == 2'b10 && addr_q[1:0] != 2'b00)
          | !mapped
          | (we_q && is_sw);

    case (size_q)
      2'b00:   lanes = 4'b0001 << addr_q[1:0];
      2'b01:   lanes = addr_q[1] ? 4'b1100 : 4'b0011;
      default: lanes = 4'b1111;
    endcase
    bmask = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
    case (size_q)
      2'b00:   wdata = {4{st_q[7:0]}};
      2'b01:   wdata = {2{st_q[15:0]}};
      default: wdata = st_q;
    endcase

    rword = '0;
    if (is_dmem) rword = dmem_q[widx];
    if (is_ledr) rword = io_ledr_o;
    if (is_ledg) rword = io_ledg_o;
    if (is_lcd)  rword = io_lcd_o;
    if (is_sw)   rword = sw_s2_q;
    for (int k = 0; k < N_HEX; k++)
      if (hex_sel[k]) rword = io_hex_o[k];

    lshift = rword >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'b00:   ld_d = uns_q ? {24'b0, lshift[7:0]}
                            : {{24{lshift[7]}}, lshift[7:0]};
      2'b01:   ld_d = uns_q ? {16'b0, lshift[15:0]}
                            : {{16{lshift[15]}}, lshift[15:0]};
      default: ld_d = lshift;
    endcase
    if (err_d) ld_d = '0;
  end

  assign wr_en = acc && we_q && !err_d && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= 2'b00;
      addr_q    <= '0;
      st_q      <= '0;
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      ld_q      <= '0;
      io_ledr_o <= '0;
      io_ledg_o <= '0;
      io_lcd_o  <= '0;
      for (int k = 0; k < N_HEX; k++) io_hex_o[k] <= '0;
    end else begin
      state_q <= state_d;
      sw_s1_q <= sw_i;
      sw_s2_q <= sw_s1_q;
      if (state_q == IDLE && req_i) begin
        we_q   <= we_i;
        uns_q  <= uns_i;
        size_q <= size_i;
        addr_q <= addr_i;
        st_q   <= st_i;
      end
      ack_q <= acc;
      err_q <= acc && err_d;
      ld_q  <= (acc && !we_q) ? ld_d : '0;
      if (wr_en && is_ledr)
        io_ledr_o <= (io_ledr_o & ~bmask) | (wdata & bmask);
      if (wr_en && is_ledg)
        io_ledg_o <= (io_ledg_o & ~bmask) | (wdata & bmask);
      if (wr_en && is_lcd)
        io_lcd_o <= (io_lcd_o & ~bmask) | (wdata & bmask);
      for (int k = 0; k < N_HEX; k++)
        if (wr_en && hex_sel[k])
          io_hex_o[k] <= (io_hex_o[k] & ~bmask) | (wdata & bmask);
    end
  end

  // Data memory keeps its contents across reset.
  always_ff @(posedge clk_i) begin
    if (wr_en && is_dmem)
      for (int b = 0; b < 4; b++)
        if (lanes[b]) dmem_q[widx][8*b +: 8] <= wdata[8*b +: 8];
  end

endmodule

// File: tb/tb_lsu_mmio.sv
// Scoreboard bench for lsu_mmio: expected ack/err/ld queued at request time,
// popped and compared by a monitor when ack_o fires.
module tb_lsu_mmio;

  logic        clk_i = 1'b0;
  logic        rst_i, req_i, we_i, uns_i;
  logic [1:0]  size_i;
  logic [11:0] addr_i;
  logic [31:0] st_i, sw_i;
  logic        busy_o, ack_o, err_o;
  logic [31:0] ld_o, io_ledr_o, io_ledg_o, io_lcd_o;
  logic [31:0] io_hex_o [0:7];

  lsu_mmio #(.ADDR_W(12), .DMEM_AW(9), .N_HEX(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i),
    .size_i(size_i), .uns_i(uns_i), .addr_i(addr_i), .st_i(st_i),
    .sw_i(sw_i), .busy_o(busy_o), .ack_o(ack_o), .err_o(err_o),
    .ld_o(ld_o), .io_hex_o(io_hex_o), .io_ledr_o(io_ledr_o),
    .io_ledg_o(io_ledg_o), .io_lcd_o(io_lcd_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        err;
    logic [31:0] ld;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   ack_cnt = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    if (mon_en) begin
      if (ack_o) begin
        ack_cnt++;
        if (q.size() == 0) chk("spurious_ack", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("err", {31'b0, err_o}, {31'b0, e.err});
          chk("ld", ld_o, e.ld);
          chk("latency", cyc, e.cyc);
        end
      end else chk("ld_idle", ld_o, 32'd0);
    end
  end

  task automatic rq(input logic we, input logic [1:0] sz, input logic uns,
                    input logic [11:0] a, input logic [31:0] d,
                    input logic eerr, input logic [31:0] eld);
    int n = 0;
    @(negedge clk_i);
    while (busy_o && n < 20) begin @(negedge clk_i); n++; end
    if (busy_o) chk("busy_timeout", 32'd1, 32'd0);
    we_i = we; size_i = sz; uns_i = uns; addr_i = a; st_i = d;
    req_i = 1'b1;
    q.push_back('{eerr, eld, cyc + 2});
    @(posedge clk_i);
    #1 req_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 20) begin @(negedge clk_i); #1; n++; end
    if (q.size() != 0) begin
      chk("ack_timeout", q.size(), 32'd0);
      q.delete();
    end
  endtask

  int base, cnt0;

  initial begin
    rst_i = 1'b1; req_i = 1'b1; we_i = 1'b1; size_i = 2'b10; uns_i = 1'b0;
    addr_i = 12'h880; st_i = 32'hFFFF_FFFF; sw_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0; req_i = 1'b0;
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_ack", {31'b0, ack_o}, 32'd0);
    chk("rst_err", {31'b0, err_o}, 32'd0);
    chk("rst_ld", ld_o, 32'd0);
    chk("rst_ledr", io_ledr_o, 32'd0);
    chk("rst_hex0", io_hex_o[0], 32'd0);
    mon_en = 1'b1;

    // DMEM word/byte/half traffic, issued back to back
    rq(1, 2'b10, 0, 12'h010, 32'hDEAD_BEEF, 0, 32'h0);
    rq(0, 2'b10, 0, 12'h010, 32'h0, 0, 32'hDEAD_BEEF);
    rq(1, 2'b00, 0, 12'h013, 32'hFFFF_FF7F, 0, 32'h0);
    rq(0, 2'b00, 0, 12'h012, 32'h0, 0, 32'hFFFF_FFAD);
    rq(0, 2'b10, 0, 12'h010, 32'h0, 0, 32'h7FAD_BEEF);
    rq(0, 2'b01, 1, 12'h012, 32'h0, 0, 32'h0000_7FAD);
    rq(0, 2'b01, 0, 12'h011, 32'h0, 1, 32'h0);
    rq(0, 2'b01, 0, 12'h010, 32'h0, 0, 32'hFFFF_BEEF);
    rq(1, 2'b01, 0, 12'h010, 32'hAAAA_1234, 0, 32'h0);
    rq(0, 2'b00, 1, 12'h011, 32'h0, 0, 32'h0000_0012);
    rq(1, 2'b10, 0, 12'h012, 32'h0, 1, 32'h0);
    rq(0, 2'b11, 0, 12'h010, 32'h0, 1, 32'h0);
    rq(0, 2'b10, 0, 12'h010, 32'h0, 0, 32'h7FAD_1234);
    rq(0, 2'b10, 0, 12'h820, 32'h0, 1, 32'h0);
    rq(0, 2'b10, 0, 12'h8B0, 32'h0, 1, 32'h0);
    drain();

    // Peripherals
    rq(1, 2'b10, 0, 12'h81C, 32'h0000_0012, 0, 32'h0);
    drain();
    chk("hex7", io_hex_o[7], 32'h0000_0012);
    rq(1, 2'b10, 0, 12'h900, 32'hFFFF_FFFF, 1, 32'h0);
    drain();
    chk("hex7_keep", io_hex_o[7], 32'h0000_0012);
    chk("ledr_keep", io_ledr_o, 32'h0);
    chk("ledg_keep", io_ledg_o, 32'h0);
    chk("lcd_keep", io_lcd_o, 32'h0);
    rq(1, 2'b00, 0, 12'h881, 32'h0000_00AB, 0, 32'h0);
    rq(1, 2'b01, 0, 12'h8A2, 32'h0000_BEEF, 0, 32'h0);
    rq(0, 2'b10, 0, 12'h880, 32'h0, 0, 32'h0000_AB00);
    rq(0, 2'b01, 1, 12'h8A2, 32'h0, 0, 32'h0000_BEEF);
    rq(0, 2'b10, 0, 12'h81C, 32'h0, 0, 32'h0000_0012);
    drain();
    chk("ledr_lane", io_ledr_o, 32'h0000_AB00);
    chk("lcd_lane", io_lcd_o, 32'hBEEF_0000);

    // Switches through the synchronizer
    @(negedge clk_i);
    sw_i = 32'h0000_00A5;
    repeat (3) @(negedge clk_i);
    rq(0, 2'b10, 0, 12'h900, 32'h0, 0, 32'h0000_00A5);
    rq(0, 2'b00, 0, 12'h900, 32'h0, 0, 32'hFFFF_FFA5);
    drain();

    // req_i held high: accepted only on IDLE edges
    cnt0 = ack_cnt;
    @(negedge clk_i);
    we_i = 1'b0; size_i = 2'b10; uns_i = 1'b0; addr_i = 12'h900;
    req_i = 1'b1;
    base = cyc;
    for (int i = 0; i < 3; i++) q.push_back('{1'b0, 32'h0000_00A5, base + 2 + 2*i});
    repeat (6) @(posedge clk_i);
    #1 req_i = 1'b0;
    drain();
    repeat (2) @(negedge clk_i);
    chk("held_acks", ack_cnt - cnt0, 32'd3);

    // Reset during ACCESS aborts a LEDR store
    cnt0 = ack_cnt;
    @(negedge clk_i);
    we_i = 1'b1; size_i = 2'b10; addr_i = 12'h880; st_i = 32'h55;
    req_i = 1'b1;
    @(posedge clk_i);
    #1 req_i = 1'b0; rst_i = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("abort_busy", {31'b0, busy_o}, 32'd0);
    chk("abort_ledr", io_ledr_o, 32'h0);
    chk("abort_lcd", io_lcd_o, 32'h0);
    @(negedge clk_i);
    chk("abort_acks", ack_cnt - cnt0, 32'd0);
    rq(0, 2'b10, 0, 12'h010, 32'h0, 0, 32'h7FAD_1234);
    rq(0, 2'b10, 0, 12'h880, 32'h0, 0, 32'h0);
    drain();

    repeat (2) @(negedge clk_i);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
